// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use comparator: a load in ID/EX whose destination feeds the instruction in IF/ID.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       idex_memrd_i,
  input  logic [4:0] idex_rd_i,
  input  logic [4:0] ifid_rs1_i,
  input  logic [4:0] ifid_rs2_i,
  output logic       load_use_o
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use_o = idex_memrd_i && (idex_rd_i != REG_ZERO) &&
                      ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges memory freeze, branch flush and load-use
// stall into register enables, and runs the data-memory handshake with a watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             exmem_memrd_i,
  input  logic             exmem_memwr_i,
  input  logic             mem_ack_i,
  input  logic             idex_memrd_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             branch_taken_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             idex_we_o,
  output logic             exmem_we_o,
  output logic             memwb_we_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             memwb_bubble_o,
  output logic             mem_req_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_op;
  logic load_use;
  logic freeze;

  assign mem_op = exmem_memrd_i | exmem_memwr_i;

  pipe_hazard_detect u_hazard (
    .idex_memrd_i (idex_memrd_i),
    .idex_rd_i    (idex_rd_i),
    .ifid_rs1_i   (ifid_rs1_i),
    .ifid_rs2_i   (ifid_rs2_i),
    .load_use_o   (load_use)
  );

  // DONE is never frozen: the access retires there, and a held branch acts then.
  assign freeze = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && mem_op);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          state_d = ST_WAIT;
          wcnt_d  = 8'd0;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          state_d = ST_DONE;
        end else if (wcnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_we_o        = 1'b1;
    ifid_we_o      = 1'b1;
    idex_we_o      = 1'b1;
    exmem_we_o     = 1'b1;
    memwb_we_o     = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    memwb_bubble_o = 1'b0;
    mem_req_o      = freeze;
    if (freeze) begin
      pc_we_o        = 1'b0;
      ifid_we_o      = 1'b0;
      idex_we_o      = 1'b0;
      exmem_we_o     = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (load_use) begin
      pc_we_o       = 1'b0;
      ifid_we_o     = 1'b0;
      idex_bubble_o = 1'b1;
    end
    // Reset overrides everything without waiting for a clock edge.
    if (!rst_i) begin
      pc_we_o        = 1'b0;
      ifid_we_o      = 1'b0;
      idex_we_o      = 1'b0;
      exmem_we_o     = 1'b0;
      memwb_we_o     = 1'b0;
      ifid_flush_o   = 1'b0;
      idex_bubble_o  = 1'b0;
      memwb_bubble_o = 1'b0;
      mem_req_o      = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!pc_we_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 8'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign err_o       = err_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver predicts each cycle's outputs from a
// behavioural model, a monitor compares them against the DUT before the next edge.
module tb_pipe_ctrl;

  localparam int TMO   = 4;
  localparam int CW    = 16;
  localparam int SATMX = 65535;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          exmem_memrd_i = 1'b0, exmem_memwr_i = 1'b0, mem_ack_i = 1'b0;
  logic          idex_memrd_i = 1'b0, branch_taken_i = 1'b0;
  logic [4:0]    idex_rd_i = 5'd0, ifid_rs1_i = 5'd0, ifid_rs2_i = 5'd0;
  logic          pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o;
  logic          ifid_flush_o, idex_bubble_o, memwb_bubble_o, mem_req_o, err_o;
  logic [CW-1:0] stall_cnt_o;

  pipe_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .exmem_memrd_i(exmem_memrd_i), .exmem_memwr_i(exmem_memwr_i), .mem_ack_i(mem_ack_i),
    .idex_memrd_i(idex_memrd_i), .idex_rd_i(idex_rd_i),
    .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i), .branch_taken_i(branch_taken_i),
    .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o), .idex_we_o(idex_we_o),
    .exmem_we_o(exmem_we_o), .memwb_we_o(memwb_we_o), .ifid_flush_o(ifid_flush_o),
    .idex_bubble_o(idex_bubble_o), .memwb_bubble_o(memwb_bubble_o),
    .mem_req_o(mem_req_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [9:0]    ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Model of the memory access: an access is either absent, waiting on ack
  // (with a count of cycles spent waiting), or retiring in the current cycle.
  bit m_waiting;
  bit m_retiring;
  int m_waited;
  bit m_err;
  int m_stalls;

  task automatic step(input bit rst, input bit mrd, input bit mwr, input bit ack,
                      input bit lrd, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input bit br);
    exp_t e;
    bit frozen, lu, pc, ifid, idex, exm, flush, idb, wbb;
    @(negedge clk_i);
    rst_i = rst; exmem_memrd_i = mrd; exmem_memwr_i = mwr; mem_ack_i = ack;
    idex_memrd_i = lrd; idex_rd_i = rd; ifid_rs1_i = rs1; ifid_rs2_i = rs2;
    branch_taken_i = br;
    if (!rst) begin
      m_waiting = 0; m_retiring = 0; m_waited = 0; m_err = 0; m_stalls = 0;
      e.ctl = '0;
      e.cnt = '0;
      q.push_back(e);
      return;
    end
    frozen = m_waiting || (!m_retiring && (mrd || mwr));
    lu = lrd && (rd != 0) && ((rd == rs1) || (rd == rs2));
    pc = 1; ifid = 1; idex = 1; exm = 1; flush = 0; idb = 0; wbb = 0;
    if (frozen) begin
      pc = 0; ifid = 0; idex = 0; exm = 0; wbb = 1;
    end else if (br) begin
      flush = 1; idb = 1;
    end else if (lu) begin
      pc = 0; ifid = 0; idb = 1;
    end
    e.ctl = {pc, ifid, idex, exm, 1'b1, flush, idb, wbb, frozen, m_err};
    e.cnt = CW'(m_stalls);
    q.push_back(e);
    // advance the model across the coming clock edge
    if (!pc && m_stalls < SATMX) m_stalls++;
    if (m_waiting) begin
      m_waited++;
      if (ack) begin
        m_waiting = 0; m_retiring = 1;
      end else if (m_waited == TMO) begin
        m_err = 1; m_waiting = 0; m_retiring = 1;
      end
    end else if (m_retiring) begin
      m_retiring = 0;
    end else if (mrd || mwr) begin
      m_waiting = 1; m_waited = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  // Monitor: compares the oldest prediction against the DUT, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if ({pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o, ifid_flush_o,
             idex_bubble_o, memwb_bubble_o, mem_req_o, err_o} !== e.ctl) begin
          failures++;
          $display("FAIL ctl t=%0t got=%b want=%b (pc,ifid,idex,exmem,memwb,flush,idexb,memwbb,req,err)",
                   $time, {pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o,
                   ifid_flush_o, idex_bubble_o, memwb_bubble_o, mem_req_o, err_o}, e.ctl);
        end
        checks++;
        if (stall_cnt_o !== e.cnt) begin
          failures++;
          $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt_o, e.cnt);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [4:0] rd, r1, r2;
    // reset
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(2);
    // load with ack on the first WAIT cycle, ack in IDLE/DONE ignored
    step(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(1);
    // load-use on rs2, then with rd=0
    step(1, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
    step(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    // branch together with load-use
    step(1, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2, 1);
    // branch arriving during a freeze, still held at DONE
    step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    step(1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 1);
    step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(2);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rd = 5'($urandom_range(0, 3));
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      step(1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, rd, r1, r2,
           $urandom_range(0, 5) == 0);
    end
    // store with no ack: watchdog after TMO WAIT cycles, error stays sticky
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(1);
    for (int i = 0; i < TMO + 1; i++) step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(3);
    step(1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0);
    idle(2);
    // reset dropped in the middle of WAIT, then released
    step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(2);
    // long load-use stall drives the counter into saturation
    for (int i = 0; i < 70000; i++) step(1, 0, 0, 0, 1, 5'd9, 5'd9, 5'd9, 0);
    idle(2);
    @(negedge clk_i);
    @(negedge clk_i);
    #4;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage core: it drives the write-enables, bubble and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It merges three stall/flush sources (multi-cycle data-memory access, load-use hazard, taken branch) with fixed priority. It also runs the request/acknowledge handshake to data memory, with a timeout watchdog and a stall-cycle counter. It sits beside the datapath and owns no data, only control.

## Interface
- TIMEOUT, 64: maximum WAIT cycles before the watchdog fires; legal range 2..255.
- CNT_W, 16: stall counter width.

- clk_i  in  1  core clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- exmem_memrd_i  in  1  EX/MEM holds a load.
- exmem_memwr_i  in  1  EX/MEM holds a store.
- mem_ack_i  in  1  data memory has completed the access; sampled only in WAIT.
- idex_memrd_i  in  1  ID/EX holds a load.
- idex_rd_i  in  5  ID/EX destination register.
- ifid_rs1_i, ifid_rs2_i  in  5 each  IF/ID source registers.
- branch_taken_i  in  1  branch resolved taken in EX.
- pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o  out  1 each  register load enables.
- ifid_flush_o  out  1  IF/ID loads a NOP.
- idex_bubble_o  out  1  ID/EX loads control-zero.
- memwb_bubble_o  out  1  MEM/WB loads WB=0.
- mem_req_o  out  1  data-memory request.
- err_o  out  1  sticky watchdog error.
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_we_o=0.

## Operation
- Memory FSM states:
  - IDLE: if exmem_memrd_i|exmem_memwr_i, assert mem_req_o, freeze, go to WAIT. Otherwise no freeze.
  - WAIT: mem_req_o=1 and freeze. On mem_ack_i go to DONE. If the wait counter reaches TIMEOUT, set err_o and go to DONE.
  - DONE: mem_req_o=0, no freeze, all register enables 1, then go to IDLE. The access therefore retires exactly once.
- Freeze: pc/ifid/idex/exmem _we_o=0, memwb_we_o=1, memwb_bubble_o=1. The frozen WB instruction is not rewritten.
- Load-use, evaluated only when not frozen: idex_memrd_i && idex_rd_i!=0 && (idex_rd_i==ifid_rs1_i || idex_rd_i==ifid_rs2_i). Response: pc_we_o=0, ifid_we_o=0, idex_bubble_o=1, other enables 1.
- Branch, evaluated only when not frozen: ifid_flush_o=1, idex_bubble_o=1, all enables 1.
- Priority: freeze > branch > load-use. A branch coinciding with load-use wins, because the dependent instruction is flushed. A branch arriving during a freeze is held by the frozen EX stage and acts in DONE.
- Default, with no event: all enables 1, all bubble/flush 0.
- Wait counter: 8 bits, cleared on entry to WAIT.
- stall_cnt_o: increments in every cycle with pc_we_o=0 while out of reset, and saturates at all-ones.
- err_o: set by the watchdog and cleared only by reset.

## Timing
- Reset (rst_i low), effective immediately and independent of the clock:
  - state=IDLE, wait counter=0, stall_cnt_o=0, err_o=0.
  - All outputs forced to 0, including all enables.
- Reset asserted mid-WAIT drops mem_req_o in the same cycle. The access is abandoned.
- Outputs are combinational from the registered state and current inputs. There is no output register.
- Memory access with ack on the first WAIT cycle takes 3 cycles (IDLE, WAIT, DONE), giving 2 stall cycles. Each extra ack-latency cycle adds one stall.
- Back-to-back memory ops: DONE advances the next op into EX/MEM, which is detected in the following IDLE. There are no idle gaps beyond DONE.
- mem_ack_i seen in IDLE or DONE is ignored.
- Load-use stalls for exactly 1 cycle. Branch flush lasts exactly 1 cycle.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - the default TIMEOUT and CNT_W;
  - a NOP/zero-register constant (5'd0).
- Sub-module pipe_hazard_detect is the purely combinational load-use comparator, instantiated once.
- FSM, counters and output mux live in pipe_ctrl.

## Test plan
- Load in EX/MEM, ack on 1st WAIT cycle:
  - mem_req_o high for 2 cycles; pc_we_o low 2 cycles; memwb_bubble_o=1 in both.
  - DONE has all enables 1; stall_cnt_o=2.
- idex_memrd_i=1, idex_rd_i=5, ifid_rs2_i=5 (no memory op):
  - 1 cycle with pc_we_o=0, ifid_we_o=0, idex_bubble_o=1.
  - Same case with idex_rd_i=0 gives no stall.
- branch_taken_i together with the load-use condition:
  - ifid_flush_o=1, idex_bubble_o=1, pc_we_o=1; stall_cnt_o unchanged.
- Store with no ack, TIMEOUT=4:
  - err_o rises after 4 WAIT cycles, FSM passes through DONE, err_o stays 1 until rst_i low.
- rst_i pulsed low during WAIT:
  - mem_req_o and all enables drop asynchronously; after release, state=IDLE, stall_cnt_o=0.
- 70000 consecutive stalled cycles with CNT_W=16:
  - stall_cnt_o holds at 65535.
